ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
Registered RV32I instruction decode stage with a valid/ready handshake on both sides.
- Decodes one instruction per cycle into the core's existing control-bundle encodings.
- Adds illegal-instruction detection, optional M-extension decode, SYSTEM/FENCE classification, pipeline flush and a saturating illegal-instruction counter.
- Sits between fetch and the register-file/ALU stage.

Parameters:
XLEN, 32, width of PC path
EN_M, 0, 1 = decode RV32M (OP with funct7=0000001); 0 = those encodings are illegal
CNT_W, 8, width of saturating illegal_cnt

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  drop all buffered instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  PC of the bundle
out_rs1, out_rs2, out_rd  out  5 each  register indices
W_EN  out  1  register write; forced 0 when rd=0 or illegal
rd_sel  out  2  writeback source: 00 PC+4, 01 imm, 10 ALU, 11 data mem
imm_type  out  3  000 none, 001 I, 010 B, 011 U, 100 J, 101 S
imm_sel  out  1  ALU operand B: 1 imm, 0 rs2
sel2  out  1  ALU operand A: 1 rs1, 0 PC
ALU_op  out  4  0001 AND, 0010 OR, 0011 XOR, 0100 ADD, 0101 SUB, 0110 SLL, 0111 SRL, 1000 SLTU, 1001 SLT, 1010 SRA
write_op, read_op  out  1 each  store / load enable
data_extend  out  1  1 = sign-extend load
mem_width  out  2  00 word, 01 half, 10 byte
jump_ctrl  out  3  branch funct3; 010 JAL/JALR; 011 none
branch_base  out  1  1 PC, 0 rs1
muldiv_en  out  1  M-extension op; funct3 in muldiv_op
muldiv_op  out  3  M funct3
sys_op  out  2  00 none, 01 FENCE, 10 ECALL, 11 EBREAK
illegal  out  1  bundle is an illegal instruction
illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (rst_n=0, async): out_valid=0; in_ready=1; every bundle field=0 except jump_ctrl=011; illegal_cnt=0.
- Datapath: combinational decode of in_instr, then a 2-entry skid buffer (main + skid).
- Accept on in_valid&in_ready; latency 1 cycle to out_valid.
- in_ready is registered; it is 1 iff the skid entry is empty.
- Downstream stall (out_ready=0 with out_valid=1): bundle held stable. An in-flight accept lands in skid; in_ready drops the next cycle.
- Simultaneous accept and drain with skid empty: main is replaced; no bubble.
- Skid drains into main on the first out_ready cycle; in_ready returns to 1 the cycle after.
- flush: at the next edge both entries become invalid and in_ready=1. An input offered in the flush cycle is dropped and not counted. flush has priority over all events.
- Decode per opcode:
  - LUI: U, rd_sel 01.
  - AUIPC: U, sel2=0, imm_sel=1, ADD, rd_sel 10.
  - JAL: J, base 1, jump 010, rd_sel 00.
  - JALR: I, base 0, jump 010, rd_sel 00; funct3≠000 is illegal.
  - Branch: B, imm_sel=0, sel2=1, jump=funct3; BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; funct3 010/011 illegal.
  - Load: I, ADD, read_op, rd_sel 11; LB/LH/LW/LBU/LHU set width and extend; other funct3 illegal.
  - Store: S, ADD, write_op; SB/SH/SW only.
  - OP-IMM: I, imm_sel=1, sel2=1, rd_sel 10. SLLI needs funct7=0. SRLI/SRAI need funct7 0000000/0100000. Otherwise illegal.
  - OP: rd_sel 10. funct7 0000000: all eight ops. funct7 0100000: SUB/SRA only. funct7 0000001: muldiv_en if EN_M, else illegal.
  - FENCE: sys_op 01.
  - SYSTEM: imm 0 → ECALL, imm 1 → EBREAK; other values illegal.
  - Any other opcode, or in_instr[1:0]≠11: illegal.
- Illegal bundle: illegal=1, W_EN=read_op=write_op=muldiv_en=0, jump_ctrl=011, sys_op=00.
- Unused fields are always 0; no latches.
- illegal_cnt increments on accept of an illegal instruction (not flushed) and saturates at all-ones.

Decomposition:
- Package ctrl_pkg holds: opcode constants; ALU_op, imm_type, rd_sel, mem_width, jump_ctrl and sys_op codes; the decoded-bundle struct type.
- One combinational sub-module, ctrl_decoder: instr in, bundle plus illegal out.
- ctrl_decode_stage holds the skid buffer, handshake, flush logic and counter.

Test Plan:
- Reset mid-stream with out_valid=1, then release → out_valid=0, in_ready=1, jump_ctrl=011, illegal_cnt=0.
- Stream ADDI x1,x0,5 / SUB x3,x1,x2 / LW x4,8(x1), out_ready=1 → one bundle per cycle, 1-cycle latency. Bundles: ADD imm I; SUB rs2; ADD read_op width 00 rd_sel 11.
- Hold out_ready=0 for 3 cycles while sending BLTU, SB, JAL → BLTU held stable, SB in skid, in_ready=0, JAL not accepted. Release → in-order delivery: BLTU jump 110 op 1000; SB width 10; JAL jump 010 imm 100.
- MUL x5,x6,x7 with EN_M=0 → illegal=1, W_EN=0, illegal_cnt=1. With EN_M=1 → muldiv_en=1, muldiv_op=000, W_EN=1.
- 0xFFFFFFFF ×300 with CNT_W=8 → illegal_cnt saturates at 255. ADDI x0,x0,0 → W_EN=0, illegal=0.
- flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1; offered instruction never appears; counter unchanged.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, control-field encodings and decoded bundle type for the decode stage
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_AND = 4'd1, ALU_OR  = 4'd2, ALU_XOR  = 4'd3,
    ALU_ADD  = 4'd4, ALU_SUB = 4'd5, ALU_SLL = 4'd6, ALU_SRL  = 4'd7,
    ALU_SLTU = 4'd8, ALU_SLT = 4'd9, ALU_SRA = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4, IMM_S = 3'd5
  } imm_type_e;

  typedef enum logic [1:0] {RD_PC4 = 2'd0, RD_IMM = 2'd1, RD_ALU = 2'd2, RD_MEM = 2'd3} rd_sel_e;

  typedef enum logic [1:0] {MW_WORD = 2'd0, MW_HALF = 2'd1, MW_BYTE = 2'd2} mem_width_e;

  // Branches put their funct3 on jump_ctrl; these two codes are the non-branch values.
  localparam logic [2:0] JC_JUMP = 3'b010;
  localparam logic [2:0] JC_NONE = 3'b011;

  typedef enum logic [1:0] {SYS_NONE = 2'd0, SYS_FENCE = 2'd1, SYS_ECALL = 2'd2, SYS_EBREAK = 2'd3} sys_op_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       w_en;
    rd_sel_e    rd_sel;
    imm_type_e  imm_type;
    logic       imm_sel;
    logic       sel2;
    alu_op_e    alu_op;
    logic       write_op;
    logic       read_op;
    logic       data_extend;
    mem_width_e mem_width;
    logic [2:0] jump_ctrl;
    logic       branch_base;
    logic       muldiv_en;
    logic [2:0] muldiv_op;
    sys_op_e    sys_op;
    logic       illegal;
  } ctrl_bundle_t;

  // Bundle with every field inactive; also the reset and illegal-instruction base value.
  function automatic ctrl_bundle_t bundle_idle();
    ctrl_bundle_t b;
    b = '0;
    b.jump_ctrl = JC_NONE;
    return b;
  endfunction

  // Register/immediate ALU op from funct3; alt selects SUB/SRA on the 000/101 slots.
  function automatic alu_op_e alu_from_f3(logic [2:0] f3, logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational RV32I(+M) instruction decoder
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         illegal
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic [4:0]   rd;
  logic [11:0]  imm12;
  ctrl_bundle_t b;
  logic         bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign imm12  = instr[31:20];

  // Per-opcode field selection; any rejected encoding collapses to the idle bundle with illegal set.
  always_comb begin
    b   = bundle_idle();
    bad = 1'b0;
    if (instr[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          b.rd = rd; b.w_en = 1'b1; b.imm_type = IMM_U; b.rd_sel = RD_IMM;
        end
        OPC_AUIPC: begin
          b.rd = rd; b.w_en = 1'b1; b.imm_type = IMM_U;
          b.imm_sel = 1'b1; b.alu_op = ALU_ADD; b.rd_sel = RD_ALU;
        end
        OPC_JAL: begin
          b.rd = rd; b.w_en = 1'b1; b.imm_type = IMM_J;
          b.branch_base = 1'b1; b.jump_ctrl = JC_JUMP; b.rd_sel = RD_PC4;
        end
        OPC_JALR: begin
          b.rd = rd; b.rs1 = rs1; b.w_en = 1'b1; b.imm_type = IMM_I;
          b.jump_ctrl = JC_JUMP; b.rd_sel = RD_PC4;
          if (funct3 != 3'b000) bad = 1'b1;
        end
        OPC_BRANCH: begin
          b.rs1 = rs1; b.rs2 = rs2; b.imm_type = IMM_B; b.sel2 = 1'b1;
          b.jump_ctrl = funct3; b.branch_base = 1'b1;
          case (funct3[2:1])
            2'b00:   b.alu_op = ALU_SUB;
            2'b10:   b.alu_op = ALU_SLT;
            2'b11:   b.alu_op = ALU_SLTU;
            default: bad = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          b.rd = rd; b.rs1 = rs1; b.w_en = 1'b1; b.imm_type = IMM_I; b.imm_sel = 1'b1;
          b.sel2 = 1'b1; b.alu_op = ALU_ADD; b.read_op = 1'b1; b.rd_sel = RD_MEM;
          case (funct3)
            3'b000:  begin b.mem_width = MW_BYTE; b.data_extend = 1'b1; end
            3'b001:  begin b.mem_width = MW_HALF; b.data_extend = 1'b1; end
            3'b010:  begin b.mem_width = MW_WORD; b.data_extend = 1'b1; end
            3'b100:  b.mem_width = MW_BYTE;
            3'b101:  b.mem_width = MW_HALF;
            default: bad = 1'b1;
          endcase
        end
        OPC_STORE: begin
          b.rs1 = rs1; b.rs2 = rs2; b.imm_type = IMM_S; b.imm_sel = 1'b1;
          b.sel2 = 1'b1; b.alu_op = ALU_ADD; b.write_op = 1'b1;
          case (funct3)
            3'b000:  b.mem_width = MW_BYTE;
            3'b001:  b.mem_width = MW_HALF;
            3'b010:  b.mem_width = MW_WORD;
            default: bad = 1'b1;
          endcase
        end
        OPC_OP_IMM: begin
          b.rd = rd; b.rs1 = rs1; b.w_en = 1'b1; b.imm_type = IMM_I;
          b.imm_sel = 1'b1; b.sel2 = 1'b1; b.rd_sel = RD_ALU;
          b.alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
          if (funct3 == 3'b001 && funct7 != 7'b0000000) bad = 1'b1;
          if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) bad = 1'b1;
        end
        OPC_OP: begin
          b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.w_en = 1'b1; b.sel2 = 1'b1; b.rd_sel = RD_ALU;
          case (funct7)
            7'b0000000: b.alu_op = alu_from_f3(funct3, 1'b0);
            7'b0100000: begin
              if (funct3 == 3'b000 || funct3 == 3'b101) b.alu_op = alu_from_f3(funct3, 1'b1);
              else bad = 1'b1;
            end
            7'b0000001: begin
              if (EN_M) begin
                b.muldiv_en = 1'b1;
                b.muldiv_op = funct3;
              end else begin
                bad = 1'b1;
              end
            end
            default: bad = 1'b1;
          endcase
        end
        OPC_FENCE: b.sys_op = SYS_FENCE;
        OPC_SYSTEM: begin
          if (imm12 == 12'd0)      b.sys_op = SYS_ECALL;
          else if (imm12 == 12'd1) b.sys_op = SYS_EBREAK;
          else                     bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      b = bundle_idle();
      b.illegal = 1'b1;
    end
    if (b.rd == 5'd0) b.w_en = 1'b0;
  end

  assign bundle  = b;
  assign illegal = b.illegal;

endmodule

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - registered decode stage with 2-entry skid buffer, flush and illegal counter
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             W_EN,
  output logic [1:0]       rd_sel,
  output logic [2:0]       imm_type,
  output logic             imm_sel,
  output logic             sel2,
  output logic [3:0]       ALU_op,
  output logic             write_op,
  output logic             read_op,
  output logic             data_extend,
  output logic [1:0]       mem_width,
  output logic [2:0]       jump_ctrl,
  output logic             branch_base,
  output logic             muldiv_en,
  output logic [2:0]       muldiv_op,
  output logic [1:0]       sys_op,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_bundle_t    dec_b;
  logic            dec_illegal;
  ctrl_bundle_t    main_b;
  ctrl_bundle_t    skid_b;
  logic [XLEN-1:0] main_pc;
  logic [XLEN-1:0] skid_pc;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            main_free;

  ctrl_decoder #(.EN_M(EN_M)) u_decoder (
    .instr   (in_instr),
    .bundle  (dec_b),
    .illegal (dec_illegal)
  );

  // in_ready comes straight from the skid flop, so it is registered by construction.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid | out_ready;

  // Skid buffer: main refills from skid first, else from the decoder; a stalled accept parks in skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_b     <= bundle_idle();
      skid_b     <= bundle_idle();
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_b     <= skid_b;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_b     <= dec_b;
        main_pc    <= in_pc;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_b     <= dec_b;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  // Count accepted illegal instructions, holding at all-ones; flushed offers are never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (!flush && accept && dec_illegal && !(&illegal_cnt)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_pc;
  assign out_rs1     = main_b.rs1;
  assign out_rs2     = main_b.rs2;
  assign out_rd      = main_b.rd;
  assign W_EN        = main_b.w_en;
  assign rd_sel      = main_b.rd_sel;
  assign imm_type    = main_b.imm_type;
  assign imm_sel     = main_b.imm_sel;
  assign sel2        = main_b.sel2;
  assign ALU_op      = main_b.alu_op;
  assign write_op    = main_b.write_op;
  assign read_op     = main_b.read_op;
  assign data_extend = main_b.data_extend;
  assign mem_width   = main_b.mem_width;
  assign jump_ctrl   = main_b.jump_ctrl;
  assign branch_base = main_b.branch_base;
  assign muldiv_en   = main_b.muldiv_en;
  assign muldiv_op   = main_b.muldiv_op;
  assign sys_op      = main_b.sys_op;
  assign illegal     = main_b.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - self-checking bench for ctrl_decode_stage (EN_M=0 and EN_M=1 instances)
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        w_en;
    logic [1:0]  rd_sel;
    logic [2:0]  imm_type;
    logic        imm_sel;
    logic        sel2;
    logic [3:0]  alu_op;
    logic        write_op;
    logic        read_op;
    logic        data_extend;
    logic [1:0]  mem_width;
    logic [2:0]  jump_ctrl;
    logic        branch_base;
    logic        muldiv_en;
    logic [2:0]  muldiv_op;
    logic [1:0]  sys_op;
    logic        illegal;
  } exp_t;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_LW    = 32'h0080_A203;
  localparam logic [31:0] I_BLTU  = 32'h0020_E463;
  localparam logic [31:0] I_SB    = 32'h0020_8023;
  localparam logic [31:0] I_JAL   = 32'h0100_00EF;
  localparam logic [31:0] I_MUL   = 32'h0273_02B3;
  localparam logic [31:0] I_NOP0  = 32'h0000_0013;
  localparam logic [31:0] I_ONES  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready [2];
  logic        out_valid [2];
  logic [31:0] out_pc [2];
  logic [4:0]  out_rs1 [2];
  logic [4:0]  out_rs2 [2];
  logic [4:0]  out_rd [2];
  logic        W_EN [2];
  logic [1:0]  rd_sel [2];
  logic [2:0]  imm_type [2];
  logic        imm_sel [2];
  logic        sel2 [2];
  logic [3:0]  ALU_op [2];
  logic        write_op [2];
  logic        read_op [2];
  logic        data_extend [2];
  logic [1:0]  mem_width [2];
  logic [2:0]  jump_ctrl [2];
  logic        branch_base [2];
  logic        muldiv_en [2];
  logic [2:0]  muldiv_op [2];
  logic [1:0]  sys_op [2];
  logic        illegal [2];
  logic [7:0]  illegal_cnt [2];

  int checks = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   cnt_a = 0;
  int   cnt_b = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_decode_stage #(.XLEN(32), .EN_M(g == 1), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready[g]), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_pc(out_pc[g]),
      .out_rs1(out_rs1[g]), .out_rs2(out_rs2[g]), .out_rd(out_rd[g]), .W_EN(W_EN[g]),
      .rd_sel(rd_sel[g]), .imm_type(imm_type[g]), .imm_sel(imm_sel[g]), .sel2(sel2[g]),
      .ALU_op(ALU_op[g]), .write_op(write_op[g]), .read_op(read_op[g]),
      .data_extend(data_extend[g]), .mem_width(mem_width[g]), .jump_ctrl(jump_ctrl[g]),
      .branch_base(branch_base[g]), .muldiv_en(muldiv_en[g]), .muldiv_op(muldiv_op[g]),
      .sys_op(sys_op[g]), .illegal(illegal[g]), .illegal_cnt(illegal_cnt[g])
    );
  end

  // Reference decode written from the instruction-set rules.
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc, bit en_m);
    exp_t e;
    bit ok;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    logic [3:0] alu_tab [8];
    alu_tab = '{4'd4, 4'd6, 4'd9, 4'd8, 4'd3, 4'd7, 4'd2, 4'd1};
    f3 = ins[14:12]; f7 = ins[31:25]; imm = ins[31:20];
    e = '0; e.pc = pc; e.jump_ctrl = 3'b011; ok = 1;
    case (ins[6:0])
      7'h37: begin e.rd = ins[11:7]; e.w_en = 1; e.imm_type = 3; e.rd_sel = 1; end
      7'h17: begin e.rd = ins[11:7]; e.w_en = 1; e.imm_type = 3; e.imm_sel = 1; e.alu_op = 4; e.rd_sel = 2; end
      7'h6F: begin e.rd = ins[11:7]; e.w_en = 1; e.imm_type = 4; e.branch_base = 1; e.jump_ctrl = 3'b010; end
      7'h67: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.w_en = 1; e.imm_type = 1; e.jump_ctrl = 3'b010;
        ok = (f3 == 0);
      end
      7'h63: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm_type = 2; e.sel2 = 1; e.jump_ctrl = f3; e.branch_base = 1;
        e.alu_op = (f3 < 2) ? 4'd5 : (f3 < 6) ? 4'd9 : 4'd8;
        ok = (f3 != 2 && f3 != 3);
      end
      7'h03: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.w_en = 1; e.imm_type = 1; e.imm_sel = 1; e.sel2 = 1;
        e.alu_op = 4; e.read_op = 1; e.rd_sel = 3;
        e.mem_width = (f3[1:0] == 0) ? 2'd2 : (f3[1:0] == 1) ? 2'd1 : 2'd0;
        e.data_extend = (f3 < 4);
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm_type = 5; e.imm_sel = 1; e.sel2 = 1;
        e.alu_op = 4; e.write_op = 1;
        e.mem_width = (f3 == 0) ? 2'd2 : (f3 == 1) ? 2'd1 : 2'd0;
        ok = (f3 < 3);
      end
      7'h13: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.w_en = 1; e.imm_type = 1; e.imm_sel = 1; e.sel2 = 1; e.rd_sel = 2;
        e.alu_op = alu_tab[f3];
        if (f3 == 5 && f7 == 7'h20) e.alu_op = 10;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h33: begin
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.w_en = 1; e.sel2 = 1; e.rd_sel = 2;
        if (f7 == 0) e.alu_op = alu_tab[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu_op = 5;
        else if (f7 == 7'h20 && f3 == 5) e.alu_op = 10;
        else if (f7 == 7'h01 && en_m) begin e.muldiv_en = 1; e.muldiv_op = f3; end
        else ok = 0;
      end
      7'h0F: e.sys_op = 1;
      7'h73: begin
        if (imm == 0) e.sys_op = 2;
        else if (imm == 1) e.sys_op = 3;
        else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0; e.pc = pc; e.jump_ctrl = 3'b011; e.illegal = 1;
    end
    if (e.rd == 0) e.w_en = 0;
    return e;
  endfunction

  // Pipeline model: an in-order queue of at most two bundles.
  task automatic model_edge();
    exp_t da, db;
    int na, nb;
    da = ref_decode(in_instr, in_pc, 1'b0);
    db = ref_decode(in_instr, in_pc, 1'b1);
    na = qa.size(); nb = qb.size();
    if (!rst_n || flush) begin
      qa.delete(); qb.delete();
      if (!rst_n) begin cnt_a = 0; cnt_b = 0; end
    end else begin
      if (na > 0 && out_ready) void'(qa.pop_front());
      if (in_valid && na < 2) begin
        qa.push_back(da);
        if (da.illegal && cnt_a < 255) cnt_a++;
      end
      if (nb > 0 && out_ready) void'(qb.pop_front());
      if (in_valid && nb < 2) begin
        qb.push_back(db);
        if (db.illegal && cnt_b < 255) cnt_b++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic int qsize(int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qhead(int i);
    exp_t e;
    e = '0;
    if (i == 0 && qa.size() > 0) e = qa[0];
    if (i == 1 && qb.size() > 0) e = qb[0];
    return e;
  endfunction

  function automatic int mcnt(int i);
    return (i == 0) ? cnt_a : cnt_b;
  endfunction

  function automatic exp_t observed(int i);
    exp_t o;
    o.pc = out_pc[i]; o.rs1 = out_rs1[i]; o.rs2 = out_rs2[i]; o.rd = out_rd[i];
    o.w_en = W_EN[i]; o.rd_sel = rd_sel[i]; o.imm_type = imm_type[i]; o.imm_sel = imm_sel[i];
    o.sel2 = sel2[i]; o.alu_op = ALU_op[i]; o.write_op = write_op[i]; o.read_op = read_op[i];
    o.data_extend = data_extend[i]; o.mem_width = mem_width[i]; o.jump_ctrl = jump_ctrl[i];
    o.branch_base = branch_base[i]; o.muldiv_en = muldiv_en[i]; o.muldiv_op = muldiv_op[i];
    o.sys_op = sys_op[i]; o.illegal = illegal[i];
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] opcs [11];
    int k;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom();
    k = $urandom_range(0, 12);
    if (k < 11) begin
      w[6:0] = opcs[k];
      if (k == 3 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
      if (k == 7 || k == 8) begin
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      if (k == 10) begin
        case ($urandom_range(0, 2))
          0: w[31:20] = 12'd0;
          1: w[31:20] = 12'd1;
          default: ;
        endcase
      end
    end
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_pc = 0;
    repeat (2) step();
    rst_n = 1;
    in_valid = 1; in_instr = I_ADDI; in_pc = 32'h100;
    step();
    in_valid = 0;
    checks++;
    if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid[0]); end
    #2 rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid[i], in_ready[i], jump_ctrl[i], illegal_cnt[i], W_EN[i], ALU_op[i], imm_type[i]} !== {1'b0, 1'b1, 3'b011, 8'd0, 1'b0, 4'd0, 3'd0}) begin
        failures++;
        $display("FAIL reset_async dut%0d got v=%b r=%b jc=%b cnt=%0d exp v=0 r=1 jc=011 cnt=0", i, out_valid[i], in_ready[i], jump_ctrl[i], illegal_cnt[i]);
      end
    end
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid[i], in_ready[i], jump_ctrl[i], illegal_cnt[i]} !== {1'b0, 1'b1, 3'b011, 8'd0}) begin
        failures++;
        $display("FAIL reset_release dut%0d got v=%b r=%b jc=%b cnt=%0d exp v=0 r=1 jc=011 cnt=0", i, out_valid[i], in_ready[i], jump_ctrl[i], illegal_cnt[i]);
      end
    end
  endtask

  task automatic test_stream();
    logic [31:0] prog [3];
    logic [3:0]  exp_alu [3];
    logic [1:0]  exp_rdsel [3];
    prog = '{I_ADDI, I_SUB, I_LW};
    exp_alu = '{4'd4, 4'd5, 4'd4};
    exp_rdsel = '{2'd2, 2'd2, 2'd3};
    out_ready = 1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1; in_instr = prog[n]; in_pc = 32'h1000 + 4 * n;
      step();
      checks++;
      if (out_valid[0] !== 1'b1 || observed(0) !== qhead(0)) begin
        failures++; $display("FAIL stream_bundle n=%0d got=%h exp=%h", n, observed(0), qhead(0));
      end
      checks++;
      if ({ALU_op[0], rd_sel[0], out_pc[0]} !== {exp_alu[n], exp_rdsel[n], 32'h1000 + 4 * n}) begin
        failures++; $display("FAIL stream_fields n=%0d got alu=%b rdsel=%b pc=%h", n, ALU_op[0], rd_sel[0], out_pc[0]);
      end
    end
    checks++;
    if ({imm_sel[0], read_op[0], mem_width[0], W_EN[0]} !== {1'b1, 1'b1, 2'b00, 1'b1}) begin
      failures++; $display("FAIL stream_lw got imm_sel=%b read=%b width=%b wen=%b exp 1 1 00 1", imm_sel[0], read_op[0], mem_width[0], W_EN[0]);
    end
    in_valid = 0;
    step();
    checks++;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_stall();
    out_ready = 0; in_valid = 1; in_instr = I_BLTU; in_pc = 32'h200;
    step();
    checks++;
    if ({jump_ctrl[0], ALU_op[0], imm_sel[0], sel2[0]} !== {3'b110, 4'b1000, 1'b0, 1'b1} || observed(0) !== qhead(0)) begin
      failures++; $display("FAIL stall_bltu got=%h exp=%h", observed(0), qhead(0));
    end
    in_instr = I_SB; in_pc = 32'h204;
    step();
    checks++;
    if ({in_ready[0], out_pc[0]} !== {1'b0, 32'h200} || observed(0) !== qhead(0)) begin
      failures++; $display("FAIL stall_skid got ready=%b pc=%h exp ready=0 pc=200", in_ready[0], out_pc[0]);
    end
    in_instr = I_JAL; in_pc = 32'h208;
    step();
    checks++;
    if ({in_ready[0], out_valid[0], out_pc[0], jump_ctrl[0]} !== {1'b0, 1'b1, 32'h200, 3'b110}) begin
      failures++; $display("FAIL stall_hold got ready=%b v=%b pc=%h jc=%b", in_ready[0], out_valid[0], out_pc[0], jump_ctrl[0]);
    end
    out_ready = 1;
    step();
    checks++;
    if ({in_ready[0], out_pc[0], mem_width[0], write_op[0]} !== {1'b1, 32'h204, 2'b10, 1'b1} || observed(0) !== qhead(0)) begin
      failures++; $display("FAIL stall_sb got ready=%b pc=%h width=%b wr=%b", in_ready[0], out_pc[0], mem_width[0], write_op[0]);
    end
    step();
    checks++;
    if ({out_valid[0], out_pc[0], jump_ctrl[0], imm_type[0]} !== {1'b1, 32'h208, 3'b010, 3'b100} || observed(0) !== qhead(0)) begin
      failures++; $display("FAIL stall_jal got v=%b pc=%h jc=%b imm=%b", out_valid[0], out_pc[0], jump_ctrl[0], imm_type[0]);
    end
    in_valid = 0;
    step();
    checks++;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL stall_once got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_muldiv();
    out_ready = 1; in_valid = 1; in_instr = I_MUL; in_pc = 32'h300;
    step();
    in_valid = 0;
    checks++;
    if ({illegal[0], W_EN[0], illegal_cnt[0], jump_ctrl[0]} !== {1'b1, 1'b0, 8'd1, 3'b011}) begin
      failures++; $display("FAIL mul_no_m got ill=%b wen=%b cnt=%0d exp ill=1 wen=0 cnt=1", illegal[0], W_EN[0], illegal_cnt[0]);
    end
    checks++;
    if ({muldiv_en[1], muldiv_op[1], W_EN[1], illegal[1], illegal_cnt[1], out_rd[1]} !== {1'b1, 3'b000, 1'b1, 1'b0, 8'd0, 5'd5}) begin
      failures++; $display("FAIL mul_m got en=%b op=%b wen=%b ill=%b cnt=%0d", muldiv_en[1], muldiv_op[1], W_EN[1], illegal[1], illegal_cnt[1]);
    end
    step();
  endtask

  task automatic test_saturate();
    out_ready = 1; in_valid = 1; in_instr = I_ONES;
    for (int n = 0; n < 300; n++) begin
      in_pc = 32'h400 + 4 * n;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (illegal_cnt[i] !== 8'd255 || int'(illegal_cnt[i]) != mcnt(i)) begin
        failures++; $display("FAIL sat_cnt dut%0d got=%0d exp=255", i, illegal_cnt[i]);
      end
    end
    in_instr = I_NOP0;
    step();
    in_valid = 0;
    checks++;
    if ({W_EN[0], illegal[0], illegal_cnt[0]} !== {1'b0, 1'b0, 8'd255}) begin
      failures++; $display("FAIL addi_x0 got wen=%b ill=%b cnt=%0d exp 0 0 255", W_EN[0], illegal[0], illegal_cnt[0]);
    end
    step();
  endtask

  task automatic test_flush();
    rst_n = 0; in_valid = 0; flush = 0;
    step();
    rst_n = 1;
    out_ready = 0; in_valid = 1; in_instr = I_ONES; in_pc = 32'h500;
    step();
    in_instr = I_ADDI; in_pc = 32'h504;
    step();
    flush = 1; in_instr = I_SUB; in_pc = 32'h508;
    step();
    checks++;
    if ({out_valid[0], in_ready[0], illegal_cnt[0]} !== {1'b0, 1'b1, 8'd1}) begin
      failures++; $display("FAIL flush_full got v=%b r=%b cnt=%0d exp v=0 r=1 cnt=1", out_valid[0], in_ready[0], illegal_cnt[0]);
    end
    in_instr = I_ONES; in_pc = 32'h50C;
    step();
    checks++;
    if ({out_valid[0], in_ready[0], illegal_cnt[0], illegal_cnt[1]} !== {1'b0, 1'b1, 8'd1, 8'd1}) begin
      failures++; $display("FAIL flush_drop got v=%b r=%b cnt=%0d/%0d exp v=0 r=1 cnt=1", out_valid[0], in_ready[0], illegal_cnt[0], illegal_cnt[1]);
    end
    flush = 0; in_valid = 0; out_ready = 1;
    step();
    checks++;
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL flush_after got=%b exp=0", out_valid[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr = rand_instr();
      in_pc = $urandom() & 32'hFFFF_FFFC;
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (out_valid[i] !== (qsize(i) > 0) || in_ready[i] !== (qsize(i) < 2) || int'(illegal_cnt[i]) != mcnt(i)) begin
          failures++;
          $display("FAIL rand_ctrl n=%0d dut%0d got v=%b r=%b cnt=%0d exp depth=%0d cnt=%0d", n, i, out_valid[i], in_ready[i], illegal_cnt[i], qsize(i), mcnt(i));
        end
        if (qsize(i) > 0) begin
          checks++;
          if (observed(i) !== qhead(i)) begin
            failures++; $display("FAIL rand_bundle n=%0d dut%0d got=%h exp=%h", n, i, observed(i), qhead(i));
          end
        end
      end
    end
    flush = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_muldiv();
    test_saturate();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
